// File: rtl/memory_pkg.sv
// memory_pkg: types shared by the byte-lane memory slice.
//   state_t : controller state (CLEAR while zeroing the array, READY otherwise)
package memory_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

endpackage

// File: rtl/byte_lane_ram.sv
// byte_lane_ram: single-port word memory with per-byte write enables and a
// registered read port. Each byte lane is its own 8-bit array so that a plain
// block RAM with byte writes is inferred.
//   clk   : clock, rising edge
//   reset : synchronous active-high, clears only the read register
//   en    : perform a read this cycle (read register holds otherwise)
//   we    : write enable, qualified per lane by be
//   be    : per-byte write enable, bit i covers wdata[8i+7:8i]
//   addr  : word address
//   wdata : write data
//   rdata : registered read data
// RDWMODE=0 returns the stored byte on a same-address write (old data);
// RDWMODE=1 forwards the written byte (new data). Lanes not written return
// the stored byte in both modes, which yields the merged word.
module byte_lane_ram #(
  parameter int DATAWIDTH    = 32,
  parameter int DATADEPTH    = 1024,
  parameter int ADDRESSWIDTH = $clog2(DATADEPTH),
  parameter int RDWMODE      = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    we,
  input  logic [DATAWIDTH/8-1:0]  be,
  input  logic [ADDRESSWIDTH-1:0] addr,
  input  logic [DATAWIDTH-1:0]    wdata,
  output logic [DATAWIDTH-1:0]    rdata
);

  localparam int LANES = DATAWIDTH / 8;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [7:0] lane_mem [DATADEPTH];
      logic [7:0] rd_reg;

      // Storage has no reset so it maps onto block RAM.
      always_ff @(posedge clk) begin
        if (we && be[gi]) begin
          lane_mem[addr] <= wdata[8*gi +: 8];
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          rd_reg <= 8'h00;
        end else if (en) begin
          if ((RDWMODE != 0) && we && be[gi]) begin
            rd_reg <= wdata[8*gi +: 8];
          end else begin
            rd_reg <= lane_mem[addr];
          end
        end
      end

      assign rdata[8*gi +: 8] = rd_reg;
    end
  endgenerate

endmodule

// File: rtl/byte_lane_memory.sv
// byte_lane_memory: byte-enabled memory with a clear sequencer and a fixed
// latency response pipeline. Every accepted request (read or write) yields one
// rdValid pulse carrying the addressed word 1+OUTREG cycles later.
//   clk      : clock, rising edge
//   reset    : synchronous active-high; enters CLEAR and drops in-flight responses
//   clearReq : pulse in READY starts a full zero-fill of the array
//   reqValid / reqReady : request handshake (reqReady only in READY)
//   writeEn  : 1 = write, 0 = read
//   byteEn   : per-byte write enable
//   address  : word address
//   dataIn   : write data
//   rdValid  : one-cycle response strobe
//   dataOut  : response data, holds between responses
//   busy     : high while clearing
module byte_lane_memory
  import memory_pkg::*;
#(
  parameter int DATAWIDTH    = 32,
  parameter int DATADEPTH    = 1024,
  parameter int ADDRESSWIDTH = $clog2(DATADEPTH),
  parameter int OUTREG       = 0,
  parameter int RDWMODE      = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clearReq,
  input  logic                    reqValid,
  output logic                    reqReady,
  input  logic                    writeEn,
  input  logic [DATAWIDTH/8-1:0]  byteEn,
  input  logic [ADDRESSWIDTH-1:0] address,
  input  logic [DATAWIDTH-1:0]    dataIn,
  output logic                    rdValid,
  output logic [DATAWIDTH-1:0]    dataOut,
  output logic                    busy
);

  localparam int BEW = DATAWIDTH / 8;
  localparam logic [ADDRESSWIDTH-1:0] LAST_ADDR = ADDRESSWIDTH'(DATADEPTH - 1);

  state_t                  state_reg, state_next;
  logic [ADDRESSWIDTH-1:0] clr_cnt_reg, clr_cnt_next;
  logic                    accept;
  logic                    ram_we;
  logic [BEW-1:0]          ram_be;
  logic [ADDRESSWIDTH-1:0] ram_addr;
  logic [DATAWIDTH-1:0]    ram_wdata;
  logic [DATAWIDTH-1:0]    ram_rdata;
  logic                    rd_valid_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= CLEAR;
      clr_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      clr_cnt_reg <= clr_cnt_next;
    end
  end

  // Next state plus the write-port mux: the clear counter owns the RAM port
  // in CLEAR, the request interface owns it in READY.
  always_comb begin
    state_next   = state_reg;
    clr_cnt_next = clr_cnt_reg;
    accept       = 1'b0;
    ram_we       = 1'b0;
    ram_be       = '0;
    ram_addr     = address;
    ram_wdata    = dataIn;
    case (state_reg)
      CLEAR: begin
        ram_we    = 1'b1;
        ram_be    = '1;
        ram_addr  = clr_cnt_reg;
        ram_wdata = '0;
        // clearReq is deliberately not looked at here: no restart.
        if (clr_cnt_reg == LAST_ADDR) begin
          clr_cnt_next = '0;
          state_next   = READY;
        end else begin
          clr_cnt_next = clr_cnt_reg + 1'b1;
        end
      end
      READY: begin
        accept = reqValid;
        ram_we = reqValid && writeEn;
        ram_be = byteEn;
        // A request in the same cycle still completes; clear begins next cycle.
        if (clearReq) begin
          state_next = CLEAR;
        end
      end
      default: state_next = CLEAR;
    endcase
  end

  // Reset blocks array writes so contents only change through CLEAR or requests.
  byte_lane_ram #(
    .DATAWIDTH   (DATAWIDTH),
    .DATADEPTH   (DATADEPTH),
    .ADDRESSWIDTH(ADDRESSWIDTH),
    .RDWMODE     (RDWMODE)
  ) u_ram (
    .clk  (clk),
    .reset(reset),
    .en   (accept && !reset),
    .we   (ram_we && !reset),
    .be   (ram_be),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid_reg <= 1'b0;
    end else begin
      rd_valid_reg <= accept;
    end
  end

  generate
    if (OUTREG != 0) begin : g_outreg
      logic                 out_valid_reg;
      logic [DATAWIDTH-1:0] out_data_reg;

      always_ff @(posedge clk) begin
        if (reset) begin
          out_valid_reg <= 1'b0;
          out_data_reg  <= '0;
        end else begin
          out_valid_reg <= rd_valid_reg;
          if (rd_valid_reg) begin
            out_data_reg <= ram_rdata;
          end
        end
      end

      assign rdValid = out_valid_reg;
      assign dataOut = out_data_reg;
    end else begin : g_direct
      // The RAM read register only loads on accepted requests, so it holds.
      assign rdValid = rd_valid_reg;
      assign dataOut = ram_rdata;
    end
  endgenerate

  assign busy     = (state_reg == CLEAR);
  assign reqReady = (state_reg == READY);

endmodule

// File: tb/tb_byte_lane_memory.sv
// Bench for byte_lane_memory: two instances share one stimulus stream,
// dut0 (OUTREG=0, old data on write) and dut1 (OUTREG=1, new data on write),
// and are checked every cycle against a word-level model of the memory.
module tb_byte_lane_memory;
  localparam int DW = 32;
  localparam int DD = 16;
  localparam int AW = 4;

  logic          clk;
  logic          reset;
  logic          clearReq;
  logic          reqValid;
  logic          writeEn;
  logic [3:0]    byteEn;
  logic [AW-1:0] address;
  logic [DW-1:0] dataIn;
  logic          reqReady0, rdValid0, busy0;
  logic          reqReady1, rdValid1, busy1;
  logic [DW-1:0] dataOut0, dataOut1;

  byte_lane_memory #(.DATAWIDTH(DW), .DATADEPTH(DD), .ADDRESSWIDTH(AW), .OUTREG(0), .RDWMODE(0)) dut0 (
    .clk(clk), .reset(reset), .clearReq(clearReq), .reqValid(reqValid), .reqReady(reqReady0),
    .writeEn(writeEn), .byteEn(byteEn), .address(address), .dataIn(dataIn),
    .rdValid(rdValid0), .dataOut(dataOut0), .busy(busy0));

  byte_lane_memory #(.DATAWIDTH(DW), .DATADEPTH(DD), .ADDRESSWIDTH(AW), .OUTREG(1), .RDWMODE(1)) dut1 (
    .clk(clk), .reset(reset), .clearReq(clearReq), .reqValid(reqValid), .reqReady(reqReady1),
    .writeEn(writeEn), .byteEn(byteEn), .address(address), .dataIn(dataIn),
    .rdValid(rdValid1), .dataOut(dataOut1), .busy(busy1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          due;
    logic [31:0] d;
  } rsp_t;

  // Model state
  logic [31:0] mem [DD];
  int          clear_left;
  int          cyc;
  rsp_t        q0[$];
  rsp_t        q1[$];
  logic [31:0] last0, last1;
  // Responses actually observed, for the literal checks
  logic [31:0] cap0, cap1;
  rsp_t        log1[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // Effect of the upcoming rising edge, given the inputs now driven.
  task automatic update_model();
    logic [31:0] oldw, neww;
    cyc++;
    if (reset) begin
      clear_left = DD;
      q0.delete();
      q1.delete();
      last0 = '0;
      last1 = '0;
    end else if (clear_left > 0) begin
      mem[DD - clear_left] = '0;
      clear_left--;
    end else begin
      if (reqValid) begin
        oldw = mem[address];
        neww = writeEn ? merge(oldw, dataIn, byteEn) : oldw;
        q0.push_back('{cyc, oldw});
        q1.push_back('{cyc + 1, neww});
        mem[address] = neww;
      end
      if (clearReq) clear_left = DD;
    end
  endtask

  task automatic check_outputs();
    logic ev;
    chk("busy0", 32'(busy0), 32'(clear_left > 0));
    chk("ready0", 32'(reqReady0), 32'(clear_left == 0));
    chk("busy1", 32'(busy1), 32'(clear_left > 0));
    ev = (q0.size() > 0) && (q0[0].due == cyc);
    chk("rdValid0", 32'(rdValid0), 32'(ev));
    if (ev) last0 = q0.pop_front().d;
    chk("dataOut0", dataOut0, last0);
    ev = (q1.size() > 0) && (q1[0].due == cyc);
    chk("rdValid1", 32'(rdValid1), 32'(ev));
    if (ev) last1 = q1.pop_front().d;
    chk("dataOut1", dataOut1, last1);
    if (rdValid0) cap0 = dataOut0;
    if (rdValid1) begin
      cap1 = dataOut1;
      log1.push_back('{cyc, dataOut1});
    end
  endtask

  task automatic step();
    update_model();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic set_in(input logic v, input logic we, input logic [3:0] be,
                        input logic [AW-1:0] a, input logic [31:0] d, input logic clr);
    reqValid = v; writeEn = we; byteEn = be; address = a; dataIn = d; clearReq = clr;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      set_in(1'b0, 1'b0, 4'h0, '0, '0, 1'b0);
      step();
    end
  endtask

  task automatic randomize_inputs(input int clr_odds);
    set_in(1'($urandom), 1'($urandom), 4'($urandom), AW'($urandom), $urandom,
           ($urandom_range(clr_odds - 1) == 0));
  endtask

  // Counts cycles with busy high, starting from the current cycle; bounded.
  task automatic count_busy(input string name, input bit rand_req);
    int cnt = 0;
    while (busy0 && cnt < 40) begin
      cnt++;
      if (rand_req) randomize_inputs(3);
      else set_in(1'b0, 1'b0, 4'h0, '0, '0, 1'b0);
      step();
    end
    chk(name, 32'(cnt), 32'd16);
  endtask

  initial begin
    int e0;
    cyc = 0; clear_left = DD; last0 = '0; last1 = '0; cap0 = '0; cap1 = '0;
    for (int i = 0; i < DD; i++) mem[i] = '0;
    reset = 1'b1;
    set_in(1'b0, 1'b0, 4'h0, '0, '0, 1'b0);
    step(); step(); step();
    chk("reset_dataOut0", dataOut0, 32'h0);
    chk("reset_rdValid1", 32'(rdValid1), 32'h0);

    // Clear after reset, then a read of a cleared word
    reset = 1'b0;
    count_busy("busy_after_reset", 1'b0);
    cap0 = '1; cap1 = '1;
    set_in(1'b1, 1'b0, 4'h0, 4'd5, '0, 1'b0); step();
    idle(3);
    chk("read5_dut0", cap0, 32'h0000_0000);
    chk("read5_dut1", cap1, 32'h0000_0000);

    // Byte-enable merge
    set_in(1'b1, 1'b1, 4'hF, 4'd3, 32'hAABBCCDD, 1'b0); step();
    set_in(1'b1, 1'b1, 4'h5, 4'd3, 32'h11223344, 1'b0); step();
    set_in(1'b1, 1'b0, 4'h0, 4'd3, '0, 1'b0); step();
    idle(3);
    chk("merge_dut0", cap0, 32'hAA22CC44);
    chk("merge_dut1", cap1, 32'hAA22CC44);

    // Read-during-write response: old (dut0) vs new (dut1)
    set_in(1'b1, 1'b1, 4'hF, 4'd7, 32'h12345678, 1'b0); step();
    set_in(1'b1, 1'b1, 4'hF, 4'd7, 32'hCAFEBABE, 1'b0); step();
    idle(3);
    chk("rdw_old_dut0", cap0, 32'h12345678);
    chk("rdw_new_dut1", cap1, 32'hCAFEBABE);

    // Back-to-back reads through the output register
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 1'b1, 4'hF, AW'(i), 32'h100 + i, 1'b0); step();
    end
    idle(3);
    log1.delete();
    e0 = cyc + 1;
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 1'b0, 4'h0, AW'(i), '0, 1'b0); step();
    end
    idle(3);
    chk("b2b_count", 32'(log1.size()), 32'd4);
    for (int i = 0; i < 4 && i < log1.size(); i++) begin
      chk($sformatf("b2b_cycle%0d", i), 32'(log1[i].due), 32'(e0 + 1 + i));
      chk($sformatf("b2b_data%0d", i), log1[i].d, 32'h100 + i);
    end

    // Clear request: requests dropped while busy, word reads back zero
    set_in(1'b1, 1'b1, 4'hF, 4'd3, 32'hDEAD0003, 1'b0); step();
    set_in(1'b0, 1'b0, 4'h0, '0, '0, 1'b1); step();
    count_busy("busy_after_clearreq", 1'b1);
    cap0 = '1;
    set_in(1'b1, 1'b0, 4'h0, 4'd3, '0, 1'b0); step();
    idle(2);
    chk("cleared_addr3", cap0, 32'h0);

    // Reset in the middle of a clear restarts it
    set_in(1'b0, 1'b0, 4'h0, '0, '0, 1'b1); step();
    idle(8);
    reset = 1'b1; step(); step();
    reset = 1'b0;
    count_busy("busy_after_midclear_reset", 1'b0);

    // Random traffic with occasional clears and resets
    for (int n = 0; n < 500; n++) begin
      randomize_inputs(40);
      reset = ($urandom_range(149) == 0);
      step();
    end
    reset = 1'b0;
    idle(DD + 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
